// File: rtl/present_round_engine.sv
// PRESENT-80 iterative encryption engine: one full round per clock, 31 rounds,
// then final whitening with K32 while the ciphertext is held for the consumer.
module present_sbox (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
    end
endmodule

module present_round_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);
    localparam int BLOCKSIZE = 4;
    localparam int ROUNDS    = 31;
    localparam int NUM_LANES = 64 / BLOCKSIZE;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [63:0] state_reg;
    logic [79:0] key_reg;
    logic [4:0]  round;

    logic [NUM_LANES-1:0][BLOCKSIZE-1:0] sbox_in, sbox_out;
    logic [63:0] sl_out, pl_out;
    logic [79:0] key_rot, key_nxt;
    logic [3:0]  key_sb;

    // Round-key addition; in DONE this same value is the whitened ciphertext.
    assign sbox_in = state_reg ^ key_reg[79:16];

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            present_sbox u_sbox (.x(sbox_in[g]), .y(sbox_out[g]));
        end
        for (g = 0; g < 63; g++) begin : g_perm
            assign pl_out[(16*g) % 63] = sl_out[g];
        end
    endgenerate

    assign sl_out     = sbox_out;
    assign pl_out[63] = sl_out[63];

    assign key_rot = {key_reg[18:0], key_reg[79:19]};
    present_sbox u_ksbox (.x(key_rot[79:76]), .y(key_sb));
    assign key_nxt = {key_sb, key_rot[75:20], key_rot[19:15] ^ round, key_rot[14:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (round == 5'(ROUNDS)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
        out_data  = (state == DONE) ? 64'(sbox_in) : 64'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
            key_reg   <= '0;
            round     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state_reg <= in_data;
                    key_reg   <= in_key;
                    round     <= 5'd1;
                end
                RUN: begin
                    state_reg <= pl_out;
                    key_reg   <= key_nxt;
                    round     <= round + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_present_round_engine.sv
// Directed + randomized bench for present_round_engine against a loop-based PRESENT-80 model.
module tb_present_round_engine;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [63:0] in_data;
    logic [79:0] in_key;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_data;

    int total = 0, passed = 0, nfail = 0;

    present_round_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_enc(logic [63:0] pt, logic [79:0] key);
        int sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
        logic [63:0] s, t, p;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16*i) % 63] = t[i];
            s = p;
            k = (k << 61) | (k >> 19);
            k[79:76] = 4'(sb[k[79:76]]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(string tag, logic [79:0] obs, logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hold: keep out_ready low 10 cycles in DONE while poking in_valid;
    // disturb: offer a different pair throughout RUN.
    task automatic encrypt(string tag, logic [63:0] pt, logic [79:0] k, logic [63:0] exp,
                           bit hold, bit disturb);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check({tag, "_rdy"}, in_ready, 1);
        in_data = pt; in_key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_run_out"}, out_data, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            if (disturb) begin
                in_valid = 1'b1; in_data = ~pt; in_key = ~k;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, n, 31);
        check({tag, "_data"}, out_data, exp);
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                in_valid = c[0]; in_data = {$urandom, $urandom}; in_key = {16'($urandom), $urandom, $urandom};
                @(posedge clk); #1;
                check({tag, "_hold_data"}, out_data, exp);
                check({tag, "_hold_rdy"}, {out_valid, in_ready}, 2'b10);
            end
            in_valid = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_handoff"}, {in_ready, out_valid, busy, out_data}, {3'b100, 64'h0});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        #1;
        check("reset", {in_ready, out_valid, busy, out_data}, {3'b100, 64'h0});
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ready_after_rst", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_ready_idle", {in_ready, out_valid, busy}, 3'b100);

        encrypt("v0", 64'h0, 80'h0, 64'h5579C1387B228445, 0, 0);
        encrypt("v1", 64'hFFFFFFFFFFFFFFFF, 80'h0, 64'hA112FFC72F68417B, 0, 0);
        encrypt("v2", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 0);
        encrypt("v3", 64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, 64'h3333DCD3213210D2, 0, 0);
        encrypt("hold", 64'h0123456789ABCDEF, 80'h0, ref_enc(64'h0123456789ABCDEF, 80'h0), 1, 0);

        // Abort at round 15 with an asynchronous reset pulse.
        in_data = 64'hDEADBEEFCAFEF00D; in_key = 80'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_rst", {out_valid, busy, out_data}, {2'b00, 64'h0});
        #3;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rdy", {in_ready, out_valid, busy}, 3'b100);
        encrypt("after_abort", 64'h0, 80'h0, 64'h5579C1387B228445, 0, 0);

        encrypt("disturb", 64'h0, 80'h0, 64'h5579C1387B228445, 0, 1);

        for (int i = 0; i < 6; i++) begin
            logic [63:0] pt;
            logic [79:0] k;
            pt = {$urandom, $urandom};
            k  = {16'($urandom), $urandom, $urandom};
            encrypt("rand", pt, k, ref_enc(pt, k), 0, i[0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
